note_arbiter: RTL

- Control front-end for the PWM audio tone generator.
- Debounces the four note buttons (D, E, G, A) and arbitrates between simultaneous presses.
- Selects the tone period N and sequences an attack/sustain/release volume envelope.
- Drives the generator's period and volume inputs and the gate that enables the audio output pin.

---
 rtl/note_arbiter_pkg.sv | 42 ++++
 rtl/note_arbiter_btn_debounce.sv | 46 ++++
 rtl/note_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/note_arbiter_pkg.sv
// ============================================================================
// Module      : note_arbiter_pkg
// Description : Shared types, default period table and priority encoder for
//               the tone-generator control front-end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package note_arbiter_pkg;

    typedef enum logic [2:0] {
        NOTE_NONE = 3'd0,
        NOTE_D    = 3'd1,
        NOTE_E    = 3'd2,
        NOTE_G    = 3'd3,
        NOTE_A    = 3'd4
    } note_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [9:0] c_N_D_DEFAULT = 10'd665;
    localparam logic [9:0] c_N_E_DEFAULT = 10'd593;
    localparam logic [9:0] c_N_G_DEFAULT = 10'd498;
    localparam logic [9:0] c_N_A_DEFAULT = 10'd444;

    // Button vector order is {D, E, G, A}; D wins.
    function automatic note_t prio_encode(input logic [3:0] btn);
        if (btn[3])      return NOTE_D;
        else if (btn[2]) return NOTE_E;
        else if (btn[1]) return NOTE_G;
        else if (btn[0]) return NOTE_A;
        else             return NOTE_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/note_arbiter_btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer followed by a stability-count debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_btn
);

    localparam int unsigned c_CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DEBOUNCE_CYCLES);

    logic [1:0]      r_sync;
    logic [c_CW-1:0] r_cnt;
    logic            r_deb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b00;
            r_cnt  <= '0;
            r_deb  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            if (r_sync[1] == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_deb <= r_sync[1];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_btn = r_deb;

endmodule

`default_nettype wire

// File: rtl/note_arbiter.sv
// ============================================================================
// Module      : note_arbiter
// Description : Debounces four note buttons, arbitrates ownership and runs the
//               attack/sustain/release envelope feeding the PWM tone generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_arbiter
    import note_arbiter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned RAMP_DIV        = 4096,
    parameter logic [9:0]  N_D             = c_N_D_DEFAULT,
    parameter logic [9:0]  N_E             = c_N_E_DEFAULT,
    parameter logic [9:0]  N_G             = c_N_G_DEFAULT,
    parameter logic [9:0]  N_A             = c_N_A_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       D,
    input  logic       E,
    input  logic       G,
    input  logic       A,
    input  logic [7:0] volume,
    output logic [9:0] N,
    output logic       n_load,
    output logic [7:0] vol_out,
    output logic       gate,
    output logic       active
);

    localparam int unsigned     c_RW        = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [c_RW-1:0] c_RAMP_LAST = c_RW'(RAMP_DIV - 1);

    logic [3:0] w_raw;
    logic [3:0] w_deb;
    logic       w_any;
    note_t      w_pick;
    logic [9:0] w_pick_n;
    logic       w_owner_held;
    logic       w_step;

    state_t          r_state;
    note_t           r_owner;
    logic [7:0]      r_env;
    logic [9:0]      r_n;
    logic            r_n_load;
    logic            r_gate;
    logic            r_active;
    logic [c_RW-1:0] r_ramp;

    assign w_raw = {D, E, G, A};

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .i_btn(w_raw[gi]),
            .o_btn(w_deb[gi])
        );
    end

    assign w_any  = |w_deb;
    assign w_pick = prio_encode(w_deb);
    assign w_step = (r_ramp == c_RAMP_LAST);

    always_comb begin
        w_pick_n     = 10'd0;
        w_owner_held = 1'b0;
        case (w_pick)
            NOTE_D:  w_pick_n = N_D;
            NOTE_E:  w_pick_n = N_E;
            NOTE_G:  w_pick_n = N_G;
            NOTE_A:  w_pick_n = N_A;
            default: w_pick_n = 10'd0;
        endcase
        case (r_owner)
            NOTE_D:  w_owner_held = w_deb[3];
            NOTE_E:  w_owner_held = w_deb[2];
            NOTE_G:  w_owner_held = w_deb[1];
            NOTE_A:  w_owner_held = w_deb[0];
            default: w_owner_held = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_owner  <= NOTE_NONE;
            r_env    <= 8'd0;
            r_n      <= 10'd0;
            r_n_load <= 1'b0;
            r_gate   <= 1'b0;
            r_active <= 1'b0;
            r_ramp   <= '0;
        end else begin
            r_n_load <= 1'b0;
            r_ramp   <= w_step ? '0 : r_ramp + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_env <= 8'd0;
                    if (w_any) begin
                        r_owner  <= w_pick;
                        r_n      <= w_pick_n;
                        r_n_load <= 1'b1;
                        r_state  <= ST_ATTACK;
                        r_gate   <= 1'b1;
                        r_active <= 1'b1;
                        r_ramp   <= '0;
                    end
                end
                ST_ATTACK, ST_SUSTAIN: begin
                    // Holding off one cycle after a load keeps n_load a single pulse.
                    if (!w_owner_held && !r_n_load) begin
                        r_ramp <= '0;
                        if (w_any) begin
                            r_owner  <= w_pick;
                            r_n      <= w_pick_n;
                            r_n_load <= 1'b1;
                            r_state  <= ST_ATTACK;
                        end else begin
                            r_owner  <= NOTE_NONE;
                            r_state  <= ST_RELEASE;
                            r_active <= 1'b0;
                        end
                    end else if (r_state == ST_SUSTAIN) begin
                        r_env <= volume;
                    end else if (r_env >= volume) begin
                        r_env   <= volume;
                        r_state <= ST_SUSTAIN;
                        r_ramp  <= '0;
                    end else if (w_step) begin
                        r_env <= r_env + 8'd1;
                    end
                end
                ST_RELEASE: begin
                    if (w_any) begin
                        r_owner  <= w_pick;
                        r_n      <= w_pick_n;
                        r_n_load <= 1'b1;
                        r_state  <= ST_ATTACK;
                        r_active <= 1'b1;
                        r_ramp   <= '0;
                    end else if (r_env == 8'd0) begin
                        r_state <= ST_IDLE;
                        r_gate  <= 1'b0;
                        r_ramp  <= '0;
                    end else if (w_step) begin
                        r_env <= r_env - 8'd1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_gate   <= 1'b0;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign N       = r_n;
    assign n_load  = r_n_load;
    assign vol_out = r_env;
    assign gate    = r_gate;
    assign active  = r_active;

endmodule

`default_nettype wire
